// File: rtl/ysyx_25040109_lsu_axi.sv
// Load/store unit bus initiator.
// Turns one core memory request at a time into an AXI-lite style read
// (AR/R) or write (AW/W/B) transaction. It returns aligned, extended load
// data or a store completion, together with error and misalignment status.
module ysyx_25040109_lsu_axi #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    // core side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_misalign,
    // read address / data channels
    output logic [31:0] dmem_araddr,
    output logic        dmem_arvalid,
    input  logic        dmem_arready,
    input  logic [31:0] dmem_rdata,
    input  logic [1:0]  dmem_rresp,
    input  logic        dmem_rvalid,
    output logic        dmem_rready,
    // write address / data / response channels
    output logic [31:0] dmem_awaddr,
    output logic        dmem_awvalid,
    input  logic        dmem_awready,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    output logic        dmem_wen,
    output logic        dmem_wvalid,
    input  logic        dmem_wready,
    input  logic [1:0]  dmem_bresp,
    input  logic        dmem_bvalid,
    output logic        dmem_bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic        aw_done_reg;
    logic        w_done_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic        misalign_reg;

    logic        req_misalign;
    logic        ar_hs;
    logic        r_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        aw_all;
    logic        w_all;
    logic        timeout_hit;
    logic        wait_state;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    // Request legality, handshakes and timeout detection
    always_comb begin
        req_misalign = (req_size == 2'd3) ||
                       ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
        ar_hs  = dmem_arvalid && dmem_arready;
        r_hs   = dmem_rready  && dmem_rvalid;
        aw_hs  = dmem_awvalid && dmem_awready;
        w_hs   = dmem_wvalid  && dmem_wready;
        b_hs   = dmem_bready  && dmem_bvalid;
        aw_all = aw_done_reg || aw_hs;
        w_all  = w_done_reg  || w_hs;
        wait_state = (state_reg == RD_ADDR) || (state_reg == RD_DATA) ||
                     (state_reg == WR_REQ)  || (state_reg == WR_RESP);
        // The counter has already spent TIMEOUT-1 cycles; this is the last one.
        timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));
    end

    // Align the returned word to the addressed byte and extend it
    always_comb begin
        rdata_shifted = dmem_rdata >> {addr_reg[1:0], 3'b000};
        case (size_reg)
            2'd0:    load_ext = unsigned_reg ? {24'd0, rdata_shifted[7:0]}
                                             : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'd1:    load_ext = unsigned_reg ? {16'd0, rdata_shifted[15:0]}
                                             : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // State and timeout counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state selection; a completed handshake wins over a timeout in the same cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_misalign)  state_next = DONE;
                    else if (req_wen)  state_next = WR_REQ;
                    else               state_next = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (ar_hs)            state_next = RD_DATA;
                else if (timeout_hit) state_next = DONE;
            end
            RD_DATA: begin
                if (r_hs || timeout_hit) state_next = DONE;
            end
            WR_REQ: begin
                if (aw_all && w_all)  state_next = WR_RESP;
                else if (timeout_hit) state_next = DONE;
            end
            WR_RESP: begin
                if (b_hs || timeout_hit) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Clear on every state entry, count while waiting on the bus
        if (state_next != state_reg) cnt_next = '0;
        else if (wait_state)         cnt_next = cnt_reg + 1'b1;
        else                         cnt_next = '0;
    end

    // Request latches, per-channel done flags and response capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg     <= '0;
            wdata_reg    <= '0;
            size_reg     <= '0;
            unsigned_reg <= 1'b0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg     <= req_addr;
                        wdata_reg    <= req_wdata;
                        size_reg     <= req_size;
                        unsigned_reg <= req_unsigned;
                        aw_done_reg  <= 1'b0;
                        w_done_reg   <= 1'b0;
                        rdata_reg    <= '0;
                        err_reg      <= req_misalign;
                        misalign_reg <= req_misalign;
                    end
                end
                RD_ADDR: begin
                    if (!ar_hs && timeout_hit) err_reg <= 1'b1;
                end
                RD_DATA: begin
                    if (r_hs) begin
                        err_reg   <= (dmem_rresp != 2'b00);
                        rdata_reg <= (dmem_rresp != 2'b00) ? 32'd0 : load_ext;
                    end else if (timeout_hit) begin
                        err_reg   <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) aw_done_reg <= 1'b1;
                    if (w_hs)  w_done_reg  <= 1'b1;
                    if (!(aw_all && w_all) && timeout_hit) err_reg <= 1'b1;
                end
                WR_RESP: begin
                    if (b_hs)             err_reg <= (dmem_bresp != 2'b00);
                    else if (timeout_hit) err_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bus and core outputs decoded from the registered state
    always_comb begin
        req_ready     = rst && (state_reg == IDLE);
        resp_valid    = (state_reg == DONE);
        resp_rdata    = (state_reg == DONE) ? rdata_reg : 32'd0;
        resp_err      = (state_reg == DONE) && err_reg;
        resp_misalign = (state_reg == DONE) && misalign_reg;

        dmem_araddr   = addr_reg;
        dmem_arvalid  = (state_reg == RD_ADDR);
        dmem_rready   = (state_reg == RD_DATA);

        dmem_awaddr   = addr_reg;
        dmem_awvalid  = (state_reg == WR_REQ) && !aw_done_reg;
        dmem_wvalid   = (state_reg == WR_REQ) && !w_done_reg;
        dmem_wen      = dmem_wvalid;
        dmem_wdata    = wdata_reg;
        case (size_reg)
            2'd0:    dmem_wstrb = 4'b0001;
            2'd1:    dmem_wstrb = 4'b0011;
            default: dmem_wstrb = 4'b1111;
        endcase
        dmem_bready   = (state_reg == WR_RESP);
    end

endmodule

// File: tb/tb_ysyx_25040109_lsu_axi.sv
// Directed bench for the load/store bus initiator; the responder is driven
// cycle by cycle from the stimulus sequence.
module tb_ysyx_25040109_lsu_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_misalign;
    logic [31:0] dmem_araddr;
    logic        dmem_arvalid;
    logic        dmem_arready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [1:0]  dmem_rresp = '0;
    logic        dmem_rvalid = 1'b0;
    logic        dmem_rready;
    logic [31:0] dmem_awaddr;
    logic        dmem_awvalid;
    logic        dmem_awready = 1'b0;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_wen;
    logic        dmem_wvalid;
    logic        dmem_wready = 1'b0;
    logic [1:0]  dmem_bresp = '0;
    logic        dmem_bvalid = 1'b0;
    logic        dmem_bready;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_25040109_lsu_axi #(.TIMEOUT(8), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_misalign(resp_misalign),
        .dmem_araddr(dmem_araddr), .dmem_arvalid(dmem_arvalid), .dmem_arready(dmem_arready),
        .dmem_rdata(dmem_rdata), .dmem_rresp(dmem_rresp), .dmem_rvalid(dmem_rvalid),
        .dmem_rready(dmem_rready),
        .dmem_awaddr(dmem_awaddr), .dmem_awvalid(dmem_awvalid), .dmem_awready(dmem_awready),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_wen(dmem_wen),
        .dmem_wvalid(dmem_wvalid), .dmem_wready(dmem_wready),
        .dmem_bresp(dmem_bresp), .dmem_bvalid(dmem_bvalid), .dmem_bready(dmem_bready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic uns);
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wen = wen; req_addr = addr;
        req_wdata = wdata; req_size = size; req_unsigned = uns;
        step();
        req_valid = 1'b0;
    endtask

    // Full read transaction; ends with the DUT in DONE and outputs settled.
    task automatic load_txn(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                            input logic [31:0] rdata, input logic [1:0] rresp,
                            input int ar_wait, input int r_wait);
        start_req(1'b0, addr, 32'd0, size, uns);
        for (int i = 0; i < ar_wait; i++) begin
            check_eq("arvalid_wait", 32'(dmem_arvalid), 32'd1);
            check_eq("araddr_stable", dmem_araddr, addr);
            check_eq("awvalid_in_read", 32'(dmem_awvalid), 32'd0);
            step();
        end
        check_eq("arvalid_hs", 32'(dmem_arvalid), 32'd1);
        check_eq("araddr_hs", dmem_araddr, addr);
        dmem_arready = 1'b1;
        step();
        dmem_arready = 1'b0;
        check_eq("arvalid_drop", 32'(dmem_arvalid), 32'd0);
        for (int i = 0; i < r_wait; i++) begin
            check_eq("rready_wait", 32'(dmem_rready), 32'd1);
            step();
        end
        dmem_rvalid = 1'b1; dmem_rdata = rdata; dmem_rresp = rresp;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_rresp = '0;
    endtask

    // Full write transaction; aw_lag is the number of cycles AW trails W.
    task automatic store_txn(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic [3:0] exp_strb,
                             input logic [1:0] bresp, input int aw_lag);
        start_req(1'b1, addr, wdata, size, 1'b0);
        check_eq("awvalid_rise", 32'(dmem_awvalid), 32'd1);
        check_eq("wvalid_rise", 32'(dmem_wvalid), 32'd1);
        check_eq("arvalid_in_write", 32'(dmem_arvalid), 32'd0);
        check_eq("wen", 32'(dmem_wen), 32'd1);
        check_eq("wstrb", 32'(dmem_wstrb), 32'(exp_strb));
        check_eq("wdata", dmem_wdata, wdata);
        check_eq("awaddr", dmem_awaddr, addr);
        dmem_wready = 1'b1;
        if (aw_lag == 0) dmem_awready = 1'b1;
        step();
        dmem_wready = 1'b0; dmem_awready = 1'b0;
        if (aw_lag > 0) begin
            for (int i = 1; i < aw_lag; i++) begin
                check_eq("wvalid_dropped", 32'(dmem_wvalid), 32'd0);
                check_eq("wen_dropped", 32'(dmem_wen), 32'd0);
                check_eq("awvalid_held", 32'(dmem_awvalid), 32'd1);
                step();
            end
            check_eq("awvalid_late", 32'(dmem_awvalid), 32'd1);
            dmem_awready = 1'b1;
            step();
            dmem_awready = 1'b0;
        end
        check_eq("awvalid_done", 32'(dmem_awvalid), 32'd0);
        check_eq("bready", 32'(dmem_bready), 32'd1);
        dmem_bvalid = 1'b1; dmem_bresp = bresp;
        step();
        dmem_bvalid = 1'b0; dmem_bresp = '0;
    endtask

    task automatic check_resp(input string name, input logic [31:0] rdata,
                              input logic err, input logic mis);
        $display("txn %s: resp_valid=%0b rdata=0x%08h err=%0b misalign=%0b",
                 name, resp_valid, resp_rdata, resp_err, resp_misalign);
        check_eq({name, "_valid"}, 32'(resp_valid), 32'd1);
        check_eq({name, "_rdata"}, resp_rdata, rdata);
        check_eq({name, "_err"}, 32'(resp_err), 32'(err));
        check_eq({name, "_mis"}, 32'(resp_misalign), 32'(mis));
        step();
        check_eq({name, "_pulse_end"}, 32'(resp_valid), 32'd0);
        check_eq({name, "_back_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        // Asynchronous reset with no clock edge involved
        #2 rst = 1'b0;
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_arvalid", 32'(dmem_arvalid), 32'd0);
        check_eq("rst_araddr", dmem_araddr, 32'd0);
        step(); step();
        rst = 1'b1;
        #1;
        check_eq("post_rst_ready", 32'(req_ready), 32'd1);

        // Word load, 3-cycle data delay
        load_txn(32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 2, 3);
        check_resp("ld_word", 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Byte loads at offset 3: signed and unsigned
        load_txn(32'h8000_0003, 2'd0, 1'b0, 32'h8011_2233, 2'b00, 0, 0);
        check_resp("ld_byte_s", 32'hFFFF_FF80, 1'b0, 1'b0);
        load_txn(32'h8000_0003, 2'd0, 1'b1, 32'h8011_2233, 2'b00, 0, 0);
        check_resp("ld_byte_u", 32'h0000_0080, 1'b0, 1'b0);

        // Half loads at offset 2
        load_txn(32'h8000_0002, 2'd1, 1'b0, 32'h9ABC_1234, 2'b00, 1, 1);
        check_resp("ld_half_s", 32'hFFFF_9ABC, 1'b0, 1'b0);
        load_txn(32'h8000_0002, 2'd1, 1'b1, 32'h9ABC_1234, 2'b00, 0, 0);
        check_resp("ld_half_u", 32'h0000_9ABC, 1'b0, 1'b0);

        // Half store, W completes two cycles before AW
        store_txn(32'h8000_0002, 32'hABCD_1234, 2'd1, 4'b0011, 2'b00, 2);
        check_resp("st_half", 32'd0, 1'b0, 1'b0);

        // Byte store, both handshakes in one cycle
        store_txn(32'h8000_0001, 32'h0000_005A, 2'd0, 4'b0001, 2'b00, 0);
        check_resp("st_byte", 32'd0, 1'b0, 1'b0);

        // Misaligned word load: response the cycle after acceptance, no bus traffic
        start_req(1'b0, 32'h8000_0001, 32'd0, 2'd2, 1'b0);
        check_eq("mis_arvalid", 32'(dmem_arvalid), 32'd0);
        check_resp("ld_misalign", 32'd0, 1'b1, 1'b1);
        check_eq("mis_arvalid_after", 32'(dmem_arvalid), 32'd0);

        // Illegal size 3 and misaligned half store
        start_req(1'b0, 32'h8000_0000, 32'd0, 2'd3, 1'b0);
        check_resp("ld_size3", 32'd0, 1'b1, 1'b1);
        start_req(1'b1, 32'h8000_0003, 32'h1111_2222, 2'd1, 1'b0);
        check_eq("mis_st_awvalid", 32'(dmem_awvalid), 32'd0);
        check_resp("st_misalign", 32'd0, 1'b1, 1'b1);

        // Bus errors
        load_txn(32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678, 2'b10, 0, 0);
        check_resp("ld_rresp_err", 32'd0, 1'b1, 1'b0);
        store_txn(32'h8000_0008, 32'hCAFE_F00D, 2'd2, 4'b1111, 2'b10, 0);
        check_resp("st_bresp_err", 32'd0, 1'b1, 1'b0);

        // Address timeout: arvalid held for exactly 8 cycles
        start_req(1'b0, 32'h8000_0010, 32'd0, 2'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_eq("to_arvalid", 32'(dmem_arvalid), 32'd1);
            step();
        end
        check_eq("to_arvalid_drop", 32'(dmem_arvalid), 32'd0);
        check_resp("ld_timeout", 32'd0, 1'b1, 1'b0);
        // Late data pulse must be ignored
        check_eq("late_rready", 32'(dmem_rready), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        step();
        dmem_rvalid = 1'b0;
        check_eq("late_no_resp", 32'(resp_valid), 32'd0);
        check_eq("late_idle", 32'(req_ready), 32'd1);

        // Reset in the middle of a write
        start_req(1'b1, 32'h8000_0020, 32'h0BAD_F00D, 2'd2, 1'b0);
        check_eq("mid_awvalid", 32'(dmem_awvalid), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_awvalid", 32'(dmem_awvalid), 32'd0);
        check_eq("mid_rst_wvalid", 32'(dmem_wvalid), 32'd0);
        check_eq("mid_rst_wen", 32'(dmem_wen), 32'd0);
        check_eq("mid_rst_awaddr", dmem_awaddr, 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
        check_eq("mid_rst_resp", 32'(resp_valid), 32'd0);
        step();
        rst = 1'b1;
        step();
        check_eq("after_rst_resp", 32'(resp_valid), 32'd0);
        check_eq("after_rst_ready", 32'(req_ready), 32'd1);

        // Back-to-back load after recovery
        load_txn(32'h8000_0000, 2'd2, 1'b0, 32'h0123_4567, 2'b00, 0, 0);
        check_resp("ld_after_rst", 32'h0123_4567, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
